tomasulo_rs_mpy: RTL and testbench

Reservation station feeding the multiply execution unit.
- Accepts dispatched multiply ops whose operands are either values or pending producer tags.
- Snoops the common data bus (CDB) to capture pending operands.
- Issues at most one fully-ready op per cycle, oldest first, on the exe unit's issue interface. The exe unit is fixed-latency with no backpressure.

---
 rtl/tomasulo_rs_mpy.sv | 153 +++++++++++++++
 tb/tb_tomasulo_rs_mpy.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tomasulo_rs_mpy.sv
// Multiply-unit reservation station: holds dispatched ops until both operands are
// captured (at dispatch or from the CDB), then issues the oldest ready op each cycle.
module tomasulo_rs_mpy #(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     disp_vld,
    output logic                     disp_rdy,
    input  logic [TAG_W-1:0]         disp_tag,
    input  logic                     disp_a_rdy,
    input  logic [W-1:0]             disp_a,
    input  logic [TAG_W-1:0]         disp_a_tag,
    input  logic                     disp_b_rdy,
    input  logic [W-1:0]             disp_b,
    input  logic [TAG_W-1:0]         disp_b_tag,
    input  logic                     cdb_vld,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [W-1:0]             cdb_data,
    output logic                     iss_vld,
    output logic [TAG_W-1:0]         iss_tag,
    output logic [W-1:0]             iss_a,
    output logic [W-1:0]             iss_b,
    output logic [$clog2(N+1)-1:0]   occ
);

    localparam int OCC_W = $clog2(N+1);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]       vld;
    logic [N-1:0]       a_rdy;
    logic [N-1:0]       b_rdy;
    logic [TAG_W-1:0]   ent_tag [N];
    logic [TAG_W-1:0]   a_tag   [N];
    logic [TAG_W-1:0]   b_tag   [N];
    logic [W-1:0]       a_val   [N];
    logic [W-1:0]       b_val   [N];
    // older[i][j] set means entry i was dispatched before entry j
    logic [N-1:0]       older   [N];

    logic [N-1:0]       cand;
    logic [N-1:0]       sel_oh;
    logic               sel_vld;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   free_idx;
    logic [N-1:0]       a_wake;
    logic [N-1:0]       b_wake;
    logic               disp_fire;
    logic               a_byp;
    logic               b_byp;

    assign disp_rdy  = (occ != OCC_W'(N));
    assign disp_fire = disp_vld && disp_rdy;
    assign a_byp     = !disp_a_rdy && cdb_vld && (cdb_tag == disp_a_tag);
    assign b_byp     = !disp_b_rdy && cdb_vld && (cdb_tag == disp_b_tag);

    // Oldest-ready select, free-slot search and CDB tag match, all from registered state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        cand     = vld & a_rdy & b_rdy;
        sel_oh   = cand;
        sel_vld  = 1'b0;
        sel_idx  = '0;
        free_idx = '0;
        a_wake   = '0;
        b_wake   = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j != i && cand[j] && older[j][i]) sel_oh[i] = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (sel_oh[i]) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (!vld[i]) free_idx = IDX_W'(i);
        end
        for (int i = 0; i < N; i++) begin
            a_wake[i] = vld[i] && !a_rdy[i] && cdb_vld && (cdb_tag == a_tag[i]);
            b_wake[i] = vld[i] && !b_rdy[i] && cdb_vld && (cdb_tag == b_tag[i]);
        end
    end

    // Entry control state: valid/ready flags and the pairwise age relation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld   <= '0;
            a_rdy <= '0;
            b_rdy <= '0;
            for (int i = 0; i < N; i++) older[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every entry sees pre-edge values.
            for (int i = 0; i < N; i++) begin
                if (disp_fire && free_idx == IDX_W'(i)) begin
                    vld[i]   <= 1'b1;
                    a_rdy[i] <= disp_a_rdy || a_byp;
                    b_rdy[i] <= disp_b_rdy || b_byp;
                    older[i] <= '0;
                end else begin
                    if (sel_vld && sel_idx == IDX_W'(i)) vld[i] <= 1'b0;
                    if (a_wake[i]) a_rdy[i] <= 1'b1;
                    if (b_wake[i]) b_rdy[i] <= 1'b1;
                    if (disp_fire) older[i][free_idx] <= 1'b1;
                end
            end
        end
    end

    // NOTE: payload storage is deliberately not reset; it is only observed behind a set valid bit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (disp_fire && free_idx == IDX_W'(i)) begin
                ent_tag[i] <= disp_tag;
                a_tag[i]   <= disp_a_tag;
                b_tag[i]   <= disp_b_tag;
                a_val[i]   <= disp_a_rdy ? disp_a : cdb_data;
                b_val[i]   <= disp_b_rdy ? disp_b : cdb_data;
            end else begin
                if (a_wake[i]) a_val[i] <= cdb_data;
                if (b_wake[i]) b_val[i] <= cdb_data;
            end
        end
    end

    // Registered issue port and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_vld <= 1'b0;
            iss_tag <= '0;
            iss_a   <= '0;
            iss_b   <= '0;
            occ     <= '0;
        end else begin
            iss_vld <= sel_vld;
            if (sel_vld) begin
                iss_tag <= ent_tag[sel_idx];
                iss_a   <= a_val[sel_idx];
                iss_b   <= b_val[sel_idx];
            end
            case ({disp_fire, sel_vld})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_tomasulo_rs_mpy.sv
// Scoreboard bench for tomasulo_rs_mpy: an in-order list model predicts each issue
// and its cycle; a negedge monitor compares issue, occupancy and disp_rdy.
module tb_tomasulo_rs_mpy;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             disp_vld = 1'b0;
    logic             disp_rdy;
    logic [TAG_W-1:0] disp_tag = '0;
    logic             disp_a_rdy = 1'b0;
    logic [W-1:0]     disp_a = '0;
    logic [TAG_W-1:0] disp_a_tag = '0;
    logic             disp_b_rdy = 1'b0;
    logic [W-1:0]     disp_b = '0;
    logic [TAG_W-1:0] disp_b_tag = '0;
    logic             cdb_vld = 1'b0;
    logic [TAG_W-1:0] cdb_tag = '0;
    logic [W-1:0]     cdb_data = '0;
    logic             iss_vld;
    logic [TAG_W-1:0] iss_tag;
    logic [W-1:0]     iss_a;
    logic [W-1:0]     iss_b;
    logic [$clog2(N+1)-1:0] occ;

    always #5 clk = ~clk;

    tomasulo_rs_mpy #(.N(N), .W(W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .disp_vld(disp_vld), .disp_rdy(disp_rdy), .disp_tag(disp_tag),
        .disp_a_rdy(disp_a_rdy), .disp_a(disp_a), .disp_a_tag(disp_a_tag),
        .disp_b_rdy(disp_b_rdy), .disp_b(disp_b), .disp_b_tag(disp_b_tag),
        .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss_vld(iss_vld), .iss_tag(iss_tag), .iss_a(iss_a), .iss_b(iss_b),
        .occ(occ)
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             ar;
        logic [W-1:0]     a;
        logic [TAG_W-1:0] at;
        logic             br;
        logic [W-1:0]     b;
        logic [TAG_W-1:0] bt;
    } ent_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        int               due;
    } exp_t;

    ent_t m_q[$];     // waiting ops, oldest first
    exp_t exp_q[$];   // predicted issues with the edge after which they appear
    int   edge_cnt = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, exp, edge_cnt, $time);
        end
    endtask

    // Reference model: each edge issues the first fully-ready op in dispatch order,
    // then applies the CDB broadcast, then appends an accepted dispatch.
    always @(posedge clk) begin : model
        int   pre_n;
        int   k;
        ent_t e;
        exp_t x;
        if (!rst) begin
            m_q.delete();
            exp_q.delete();
        end else begin
            pre_n = m_q.size();
            k = -1;
            for (int i = 0; i < m_q.size(); i++)
                if (k < 0 && m_q[i].ar && m_q[i].br) k = i;
            if (k >= 0) begin
                x.tag = m_q[k].tag;
                x.a   = m_q[k].a;
                x.b   = m_q[k].b;
                x.due = edge_cnt + 1;
                exp_q.push_back(x);
                m_q.delete(k);
            end
            if (cdb_vld) begin
                for (int i = 0; i < m_q.size(); i++) begin
                    if (!m_q[i].ar && m_q[i].at == cdb_tag) begin m_q[i].ar = 1'b1; m_q[i].a = cdb_data; end
                    if (!m_q[i].br && m_q[i].bt == cdb_tag) begin m_q[i].br = 1'b1; m_q[i].b = cdb_data; end
                end
            end
            if (disp_vld && pre_n < N) begin
                e.tag = disp_tag;
                e.ar = disp_a_rdy; e.a = disp_a; e.at = disp_a_tag;
                e.br = disp_b_rdy; e.b = disp_b; e.bt = disp_b_tag;
                if (!e.ar && cdb_vld && cdb_tag == e.at) begin e.ar = 1'b1; e.a = cdb_data; end
                if (!e.br && cdb_vld && cdb_tag == e.bt) begin e.br = 1'b1; e.b = cdb_data; end
                m_q.push_back(e);
            end
        end
        edge_cnt++;
    end

    // Monitor: compare outputs mid-cycle against the model.
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_iss_vld", 64'(iss_vld), 64'd0);
                check("rst_occ", 64'(occ), 64'd0);
            end else begin
                check("occ", 64'(occ), 64'(m_q.size()));
                check("disp_rdy", 64'(disp_rdy), 64'(m_q.size() != N));
                if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
                    x = exp_q.pop_front();
                    check("iss_vld", 64'(iss_vld), 64'd1);
                    check("iss_tag", 64'(iss_tag), 64'(x.tag));
                    check("iss_a", 64'(iss_a), 64'(x.a));
                    check("iss_b", 64'(iss_b), 64'(x.b));
                end else begin
                    check("iss_vld_idle", 64'(iss_vld), 64'd0);
                end
            end
        end
    end

    task automatic drive(input logic dv, input logic [TAG_W-1:0] t,
                         input logic ar, input logic [W-1:0] a, input logic [TAG_W-1:0] at,
                         input logic br, input logic [W-1:0] b, input logic [TAG_W-1:0] bt,
                         input logic cv, input logic [TAG_W-1:0] ct, input logic [W-1:0] cd);
        @(negedge clk);
        disp_vld = dv; disp_tag = t;
        disp_a_rdy = ar; disp_a = a; disp_a_tag = at;
        disp_b_rdy = br; disp_b = b; disp_b_tag = bt;
        cdb_vld = cv; cdb_tag = ct; cdb_data = cd;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic cdb(input logic [TAG_W-1:0] t, input logic [W-1:0] d);
        drive(1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b1, t, d);
    endtask

    initial begin : stim
        logic [TAG_W-1:0] t;
        bit dup;
        #1 rst = 1'b0;
        #1;
        check("init_iss_vld", 64'(iss_vld), 64'd0);
        check("init_occ", 64'(occ), 64'd0);
        check("init_iss_tag", 64'(iss_tag), 64'd0);
        idle(2);
        @(negedge clk);
        #2 rst = 1'b1;

        // Ready at dispatch: issue two cycles later.
        drive(1'b1, 4'd3, 1'b1, 32'd6, 4'd0, 1'b1, 32'd7, 4'd0, 1'b0, 4'd0, 32'd0);
        idle(4);
        // A pending on tag 5, woken three cycles later.
        drive(1'b1, 4'd1, 1'b0, 32'd0, 4'd5, 1'b1, 32'd2, 4'd0, 1'b0, 4'd0, 32'd0);
        idle(2);
        cdb(4'd5, 32'h10);
        idle(4);
        // B captured by same-cycle bypass.
        drive(1'b1, 4'd4, 1'b1, 32'd9, 4'd0, 1'b0, 32'd0, 4'd2, 1'b1, 4'd2, 32'hAB);
        idle(3);
        // Fill the station, try an extra dispatch, then release all in order.
        for (int i = 0; i < 4; i++)
            drive(1'b1, 4'(i), 1'b0, 32'd0, 4'd9, 1'b1, 32'(i + 100), 4'd0, 1'b0, 4'd0, 32'd0);
        drive(1'b1, 4'd10, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 1'b0, 4'd0, 32'd0);
        idle(1);
        cdb(4'd9, 32'h55);
        idle(7);
        // Younger woken first issues first; then both woken together keep age order.
        drive(1'b1, 4'd1, 1'b0, 32'd0, 4'd7, 1'b1, 32'd11, 4'd0, 1'b0, 4'd0, 32'd0);
        drive(1'b1, 4'd2, 1'b0, 32'd0, 4'd8, 1'b1, 32'd22, 4'd0, 1'b0, 4'd0, 32'd0);
        idle(3);
        cdb(4'd8, 32'h88);
        cdb(4'd7, 32'h77);
        idle(4);
        drive(1'b1, 4'd1, 1'b0, 32'd0, 4'd7, 1'b1, 32'd33, 4'd0, 1'b0, 4'd0, 32'd0);
        drive(1'b1, 4'd2, 1'b0, 32'd0, 4'd7, 1'b1, 32'd44, 4'd0, 1'b0, 4'd0, 32'd0);
        cdb(4'd7, 32'h7E);
        idle(4);

        // Asynchronous reset while entries are held and an issue is on the port.
        drive(1'b1, 4'd6, 1'b0, 32'd0, 4'd12, 1'b1, 32'd1, 4'd0, 1'b0, 4'd0, 32'd0);
        drive(1'b1, 4'd7, 1'b0, 32'd0, 4'd12, 1'b1, 32'd2, 4'd0, 1'b0, 4'd0, 32'd0);
        drive(1'b1, 4'd8, 1'b0, 32'd0, 4'd12, 1'b1, 32'd3, 4'd0, 1'b0, 4'd0, 32'd0);
        drive(1'b1, 4'd5, 1'b1, 32'd4, 4'd0, 1'b1, 32'd5, 4'd0, 1'b0, 4'd0, 32'd0);
        idle(1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_iss_vld", 64'(iss_vld), 64'd0);
        check("async_occ", 64'(occ), 64'd0);
        m_q.delete();
        exp_q.delete();
        idle(2);
        @(negedge clk);
        #2 rst = 1'b1;
        cdb(4'd12, 32'hDEAD);
        idle(4);

        // Randomized traffic with unique in-flight result tags.
        repeat (3000) begin
            do begin
                t = 4'($urandom_range(0, 15));
                dup = 1'b0;
                foreach (m_q[i]) if (m_q[i].tag == t) dup = 1'b1;
            end while (dup);
            drive(1'($urandom_range(0, 2) != 0), t,
                  1'($urandom_range(0, 1)), 32'($urandom), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 32'($urandom), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 32'($urandom));
        end
        idle(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
